// File: rtl/camera_tx_pkg.sv
// Shared types and constants for the camera test-pattern transmitter.
package camera_tx_pkg;

  localparam int DATA_W = 12;
  localparam int CNT_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FV_PRE,
    ST_LINE,
    ST_HBLANK,
    ST_FV_POST,
    ST_VBLANK
  } state_e;

  typedef enum logic [1:0] {
    PAT_RAMP  = 2'd0,
    PAT_BAYER = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_MOVE  = 2'd3
  } pattern_e;

  // GRBG mosaic levels: green sites mid-scale, red full-scale, blue quarter-scale.
  localparam logic [DATA_W-1:0] BAYER_G = 12'h800;
  localparam logic [DATA_W-1:0] BAYER_R = 12'hFFF;
  localparam logic [DATA_W-1:0] BAYER_B = 12'h400;

endpackage

// File: rtl/camera_tx_pattern.sv
// Combinational pixel generator: maps (x, y, frame count, pattern) to a 12-bit sample.
// Only y[0] (Bayer row parity) and y[3] (checker block) affect any pattern, so only
// those bits are brought in.
module camera_tx_pattern
  import camera_tx_pkg::*;
(
  input  logic [DATA_W-1:0] i_x,
  input  logic              i_y_odd,
  input  logic              i_y_blk,
  input  logic [DATA_W-1:0] i_fcnt,
  input  pattern_e          i_sel,
  output logic [DATA_W-1:0] o_d
);

  // Pattern select and per-pattern pixel value.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves o_d unassigned (no latch).
    o_d = '0;
    case (i_sel)
      PAT_RAMP:  o_d = i_x;
      PAT_BAYER: begin
        if (!i_y_odd) o_d = i_x[0] ? BAYER_R : BAYER_G;
        else          o_d = i_x[0] ? BAYER_G : BAYER_B;
      end
      PAT_CHECK: o_d = (i_x[3] ^ i_y_blk) ? 12'hFFF : 12'h000;
      PAT_MOVE:  o_d = i_x + i_fcnt;
      default:   o_d = '0;
    endcase
  end

endmodule

// File: rtl/camera_pattern_tx.sv
// Terasic-style parallel camera transmitter (D/FVAL/LVAL) emitting synthetic frames.
// Optional macro CAMERA_TX_FRAME_CNT_EN: when defined, a 16-bit completed-frame counter
// is kept and drives frame_cnt and the moving-ramp pattern; otherwise frame_cnt reads 0
// and the moving ramp degenerates to the plain ramp.
module camera_pattern_tx
  import camera_tx_pkg::*;
#(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int H_BLANK = 160,
  parameter int FV_PRE  = 8,
  parameter int FV_POST = 8,
  parameter int V_BLANK = 45
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              run,
  input  logic [1:0]        pattern_sel,
  output logic [DATA_W-1:0] cam_D,
  output logic              cam_FVAL,
  output logic              cam_LVAL,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       frame_cnt
);

  state_e            r_state;
  pattern_e          r_sel;
  logic [CNT_W-1:0]  r_x;      // column of the next pixel to be driven
  logic [CNT_W-1:0]  r_y;      // current active line
  logic [CNT_W-1:0]  r_t;      // cycles spent in the current blanking phase
  logic [DATA_W-1:0] r_d;
  logic              r_fval;
  logic              r_lval;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] w_pix;
  logic [DATA_W-1:0] w_fcnt;
  logic              w_post_end;

  assign w_post_end = (r_state == ST_FV_POST) && (r_t == CNT_W'(FV_POST));

`ifdef CAMERA_TX_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Completed-frame counter, bumped on the FVAL falling edge; wraps naturally.
  always_ff @(posedge clk_clk) begin
    if (reset_reset)     r_frame_cnt <= '0;
    else if (w_post_end) r_frame_cnt <= r_frame_cnt + 16'd1;
  end

  assign w_fcnt    = r_frame_cnt[DATA_W-1:0];
  assign frame_cnt = r_frame_cnt;
`else
  assign w_fcnt    = '0;
  assign frame_cnt = '0;
`endif

  camera_tx_pattern u_pattern (
    .i_x     (r_x[DATA_W-1:0]),
    .i_y_odd (r_y[0]),
    .i_y_blk (r_y[3]),
    .i_fcnt  (w_fcnt),
    .i_sel   (r_sel),
    .o_d     (w_pix)
  );

  // Frame FSM; every output is registered from the state being entered.
  always_ff @(posedge clk_clk) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (reset_reset) begin
      r_state <= ST_IDLE;
      r_sel   <= PAT_RAMP;
      r_x     <= '0;
      r_y     <= '0;
      r_t     <= '0;
      r_d     <= '0;
      r_fval  <= 1'b0;
      r_lval  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (run) begin
            r_state <= ST_FV_PRE;
            r_sel   <= pattern_e'(pattern_sel);
            r_x     <= '0;
            r_y     <= '0;
            r_t     <= CNT_W'(1);
            r_fval  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_FV_PRE, ST_HBLANK: begin
          if (r_t == CNT_W'((r_state == ST_FV_PRE) ? FV_PRE : H_BLANK)) begin
            // Enter LINE with pixel 0 already on the bus, aligned to the LVAL rise.
            r_state <= ST_LINE;
            r_lval  <= 1'b1;
            r_d     <= w_pix;
            r_x     <= CNT_W'(1);
          end else begin
            r_t <= r_t + CNT_W'(1);
          end
        end
        ST_LINE: begin
          if (r_x == CNT_W'(IMG_W)) begin
            r_lval <= 1'b0;
            r_d    <= '0;
            r_x    <= '0;
            r_t    <= CNT_W'(1);
            if (r_y == CNT_W'(IMG_H - 1)) begin
              r_state <= ST_FV_POST;
            end else begin
              r_state <= ST_HBLANK;
              r_y     <= r_y + CNT_W'(1);
            end
          end else begin
            r_d <= w_pix;
            r_x <= r_x + CNT_W'(1);
          end
        end
        ST_FV_POST: begin
          if (w_post_end) begin
            r_state <= ST_VBLANK;
            r_fval  <= 1'b0;
            r_done  <= 1'b1;
            r_t     <= CNT_W'(1);
          end else begin
            r_t <= r_t + CNT_W'(1);
          end
        end
        ST_VBLANK: begin
          if (r_t == CNT_W'(V_BLANK)) begin
            if (run) begin
              r_state <= ST_FV_PRE;
              r_sel   <= pattern_e'(pattern_sel);
              r_x     <= '0;
              r_y     <= '0;
              r_t     <= CNT_W'(1);
              r_fval  <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_t     <= '0;
              r_busy  <= 1'b0;
            end
          end else begin
            r_t <= r_t + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cam_D      = r_d;
  assign cam_FVAL   = r_fval;
  assign cam_LVAL   = r_lval;
  assign busy       = r_busy;
  assign frame_done = r_done;

endmodule

// File: tb/tb_camera_pattern_tx.sv
// Directed bench for camera_pattern_tx with a 4x2 frame and short blanking.
// Cycle 1 of a frame is the first cycle FVAL reads high; period is 15 cycles.
module tb_camera_pattern_tx;

`ifdef CAMERA_TX_FRAME_CNT_EN
  localparam bit FCNT_EN = 1'b1;
`else
  localparam bit FCNT_EN = 1'b0;
`endif

  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b0;
  logic        run = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [11:0] cam_D;
  logic        cam_FVAL;
  logic        cam_LVAL;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_cnt;

  int n_total = 0;
  int n_bad   = 0;

  camera_pattern_tx #(
    .IMG_W(4), .IMG_H(2), .H_BLANK(2), .FV_PRE(1), .FV_POST(1), .V_BLANK(3)
  ) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .run         (run),
    .pattern_sel (pattern_sel),
    .cam_D       (cam_D),
    .cam_FVAL    (cam_FVAL),
    .cam_LVAL    (cam_LVAL),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk_clk = ~clk_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " fval"}, 32'(cam_FVAL), 32'd0);
    check({tag, " lval"}, 32'(cam_LVAL), 32'd0);
    check({tag, " d"},    32'(cam_D),    32'd0);
    check({tag, " busy"}, 32'(busy),     32'd0);
    check({tag, " done"}, 32'(frame_done), 32'd0);
  endtask

  // Walk cycles 1..15 of one frame. px holds the 8 expected pixels (line 0 then line 1),
  // base is frame_cnt before this frame completes. run drops after cycle drop_at and
  // pattern_sel changes to mid_sel after cycle mid_at (0 = never).
  task automatic do_frame(input string name, input logic [7:0][11:0] px, input logic [15:0] base,
                          input int drop_at, input int mid_at, input logic [1:0] mid_sel);
    logic        e_fval, e_lval;
    logic [11:0] e_d;
    logic [15:0] e_fc;
    for (int c = 1; c <= 15; c++) begin
      tick();
      e_fval = (c <= 12);
      e_lval = (c >= 2 && c <= 5) || (c >= 8 && c <= 11);
      e_d    = 12'h000;
      if (e_lval) e_d = px[(c <= 5) ? c - 2 : c - 4];
      e_fc   = FCNT_EN ? ((c >= 13) ? base + 16'd1 : base) : 16'd0;
      check($sformatf("%s c%0d fval", name, c), 32'(cam_FVAL), 32'(e_fval));
      check($sformatf("%s c%0d lval", name, c), 32'(cam_LVAL), 32'(e_lval));
      check($sformatf("%s c%0d d", name, c),    32'(cam_D),    32'(e_d));
      check($sformatf("%s c%0d done", name, c), 32'(frame_done), 32'(c == 13));
      check($sformatf("%s c%0d busy", name, c), 32'(busy),     32'd1);
      check($sformatf("%s c%0d fcnt", name, c), 32'(frame_cnt), 32'(e_fc));
      if (c == drop_at) run = 1'b0;
      if (c == mid_at)  pattern_sel = mid_sel;
    end
  endtask

  initial begin
    logic [7:0][11:0] ramp;
    logic [7:0][11:0] bayer;
    logic [7:0][11:0] mov;

    for (int k = 0; k < 8; k++) ramp[k] = 12'(k % 4);
    bayer = {12'h800, 12'h400, 12'h800, 12'h400, 12'hFFF, 12'h800, 12'hFFF, 12'h800};

    // Reset, then idle with run low.
    reset_reset = 1'b1;
    tick();
    check_idle("reset");
    check("reset fcnt", 32'(frame_cnt), 32'd0);
    tick();
    reset_reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check_idle("idle10");
    check("idle10 fcnt", 32'(frame_cnt), 32'd0);

    // Ramp frame with run held; then Bayer frame chained back to back. The Bayer frame
    // drops run during line 0 and flips pattern_sel mid-frame (must not take effect).
    pattern_sel = 2'd0;
    run = 1'b1;
    do_frame("ramp", ramp, 16'd0, 0, 0, 2'd0);
    pattern_sel = 2'd1;
    do_frame("bayer", bayer, 16'd1, 3, 4, 2'd2);
    tick();
    check_idle("after_bayer");
    tick();
    check_idle("after_bayer2");

    // Moving ramp over three consecutive frames starting from a cleared counter.
    reset_reset = 1'b1;
    tick();
    check("move rst fcnt", 32'(frame_cnt), 32'd0);
    reset_reset = 1'b0;
    tick();
    pattern_sel = 2'd3;
    run = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 8; k++) mov[k] = 12'((k % 4) + (FCNT_EN ? f : 0));
      do_frame($sformatf("move%0d", f), mov, 16'(f), (f == 2) ? 14 : 0, 0, 2'd0);
    end
    tick();
    check_idle("after_move");
    check("after_move fcnt", 32'(frame_cnt), FCNT_EN ? 32'd3 : 32'd0);

    // Reset asserted during the first HBLANK aborts the frame at once.
    pattern_sel = 2'd0;
    run = 1'b1;
    for (int c = 1; c <= 6; c++) tick();
    check("hb c6 fval", 32'(cam_FVAL), 32'd1);
    check("hb c6 lval", 32'(cam_LVAL), 32'd0);
    reset_reset = 1'b1;
    tick();
    check_idle("hb_rst");
    check("hb_rst fcnt", 32'(frame_cnt), 32'd0);
    reset_reset = 1'b0;
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle($sformatf("hb_post%0d", i));
      check($sformatf("hb_post%0d fcnt", i), 32'(frame_cnt), 32'd0);
    end

    // Restart yields a complete frame with a fresh count.
    run = 1'b1;
    do_frame("restart", ramp, 16'd0, 5, 0, 2'd0);
    tick();
    check_idle("after_restart");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
